piso_seq_ctrl: RTL

//  Sequencer for the WIDTH-bit parallel-in/serial-out shift register.
//  - Accepts parallel words over a valid/ready handshake and holds each accepted word.
//  - Drives the PISO load/shift select (s), parallel data (pd) and clock-enable (ser_en).
//  - Paces one serial bit per DIV clk cycles; this replaces ad-hoc divided clocks.
//  - Flags busy and end of frame for the upstream producer.

---
 rtl/piso_seq_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/piso_seq_ctrl.sv
// Sequencer for a WIDTH-bit parallel-in/serial-out shift register: accepts a word,
// loads it into the PISO, then paces one shift per DIV clocks with an optional idle gap.
module piso_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int DIV      = 1,
    parameter int GAP_BITS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         pd,
    output logic                     s,
    output logic                     ser_en,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     done
);

    localparam int BW      = $clog2(WIDTH);
    localparam int DW      = $clog2(DIV + 1);
    localparam int GAP_CYC = GAP_BITS * DIV;
    localparam int GW      = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t        state, nxt_state;
    logic [DW-1:0] div_cnt, nxt_div;
    logic [BW-1:0] bit_cnt, nxt_bit;
    logic [GW-1:0] gap_cnt, nxt_gap;

    always_comb begin
        nxt_state = state;
        nxt_div   = div_cnt;
        nxt_bit   = bit_cnt;
        nxt_gap   = gap_cnt;
        case (state)
            IDLE: begin
                if (in_valid) nxt_state = LOAD;
            end
            LOAD: begin
                nxt_state = SHIFT;
                nxt_div   = '0;
                nxt_bit   = '0;
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    nxt_div = '0;
                    if (bit_cnt == BIT_LAST) begin
                        nxt_bit = '0;
                        if (GAP_CYC > 0) begin
                            nxt_state = GAP;
                            nxt_gap   = '0;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end else begin
                        nxt_bit = bit_cnt + BW'(1);
                    end
                end else begin
                    nxt_div = div_cnt + DW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) nxt_state = IDLE;
                else nxt_gap = gap_cnt + GW'(1);
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with the cycle they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            pd       <= '0;
            in_ready <= 1'b1;
            s        <= 1'b1;
            ser_en   <= 1'b0;
            busy     <= 1'b0;
            bit_idx  <= '0;
            done     <= 1'b0;
        end else begin
            state   <= nxt_state;
            div_cnt <= nxt_div;
            bit_cnt <= nxt_bit;
            gap_cnt <= nxt_gap;
            if (state == IDLE && in_valid) pd <= in_data;
            in_ready <= (nxt_state == IDLE);
            busy     <= (nxt_state != IDLE);
            s        <= (nxt_state != LOAD);
            ser_en   <= (nxt_state == LOAD) ||
                        (nxt_state == SHIFT && nxt_div == DIV_LAST && nxt_bit != BIT_LAST);
            done     <= (nxt_state == SHIFT && nxt_div == DIV_LAST && nxt_bit == BIT_LAST);
            bit_idx  <= (nxt_state == SHIFT) ? nxt_bit : '0;
        end
    end

endmodule
